// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// the reset fetch address, the canonical NOP encoding and the {pc, data}
// entry layout carried through the prefetch buffer.
package fetch_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One buffered instruction: address in the upper half, word in the lower.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/pf_sync_fifo.sv
// Small show-ahead synchronous FIFO with flush. The head entry is visible
// combinationally so the consumer sees data in the cycle after the push.
// Depth need not be a power of two (the pc tag queue uses MAX_OUTSTANDING),
// so pointers wrap explicitly. A push into a full FIFO is only accepted when
// a pop happens in the same cycle; flush wins over push and pop.
module pf_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign count     = count_reg;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because empty gates every reader.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch front end: issues pipelined word fetches to instruction
// memory, buffers returned words with their addresses and hands
// {pc, instruction} pairs to decode. A redirect flushes the buffer and marks
// every in-flight response as stale so it is dropped on arrival.
//
// Optional build macro FETCH_BYPASS_EN: a response arriving while the buffer
// is empty and nothing is being dropped is shown to decode in the same cycle
// (zero load-to-use latency). Without it, decode always sees the buffer head.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = XLEN_DEFAULT,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_busy
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int CW  = $clog2(DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0]   fetch_pc_reg;
    logic [XLEN-1:0]   fetch_pc_next;
    logic [OW-1:0]     drop_cnt_reg;
    logic [OW-1:0]     drop_cnt_next;

    // The tag queue occupancy is the outstanding-request count.
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_next;
    logic              tag_full;
    logic              tag_empty;
    logic [XLEN-1:0]   tag_pc;

    logic [2*XLEN-1:0] fifo_head;
    logic [FCW-1:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    logic [CW-1:0]     credit;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              bypass;

    // Slots already promised: buffered words plus live (non-dropped) responses.
    assign credit = CW'(fifo_count) + CW'(outstanding) - CW'(drop_cnt_reg);

    // Request only when every possible live response is guaranteed a buffer
    // slot. rst is folded in so the request stays low while reset is held and
    // rises in the very first cycle after release.
    assign imem_req_valid = rst && !redirect_valid && !tag_full && !fifo_full
                            && (credit < CW'(DEPTH));
    assign imem_req_addr  = {fetch_pc_reg[XLEN-1:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses owed to requests issued before a redirect are discarded.
    assign rsp_drop = imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign bypass = rst && rsp_keep && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word taken by decode this cycle never enters the buffer.
    assign fifo_push  = rsp_keep && !(bypass && inst_ready);
    assign fifo_pop   = !fifo_empty && inst_ready;
    assign fetch_busy = !tag_empty || !fifo_empty;

    assign outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

    // In-order pc tags of accepted requests, popped by each response.
    pf_sync_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_tag_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (imem_req_addr),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head_data (tag_pc),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Prefetch buffer of {pc, instruction} pairs.
    pf_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_prefetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decode sees the buffer head, or the live response when bypassing.
    always_comb begin
        inst_valid = 1'b0;
        inst_pc    = '0;
        inst_data  = '0;
        if (!fifo_empty) begin
            inst_valid = 1'b1;
            inst_pc    = fifo_head[2*XLEN-1:XLEN];
            inst_data  = fifo_head[XLEN-1:0];
        end else if (bypass) begin
            inst_valid = 1'b1;
            inst_pc    = tag_pc;
            inst_data  = imem_rsp_data;
        end
    end

    // Next fetch address: redirect target, sequential advance, or hold.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
        end
    end

    // Drop count: a redirect marks everything still in flight after this
    // cycle as stale (a response arriving now is already not kept); otherwise
    // each dropped response retires one.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            drop_cnt_next = outstanding_next;
        end else if (rsp_drop) begin
            drop_cnt_next = drop_cnt_reg - OW'(1);
        end
    end

    // Fetch pointer and drop counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg <= START_PC;
            drop_cnt_reg <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

endmodule

// File: doc/prefetch_fetch_unit.md
Name: prefetch_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next core generation; replaces the bare PC register, PC+4 adder and next-PC mux of the single-cycle core.
- Issues pipelined requests to instruction memory over a valid/ready handshake, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned words in a DEPTH-entry prefetch FIFO and presents {pc, instruction} pairs to decode.
- A branch/jump redirect flushes the buffer and discards stale in-flight responses.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests; 1..DEPTH.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; in order, exactly one per accepted request.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  redirect fetch stream (taken branch, jal, jalr).
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  XLEN  instruction word.
- inst_pc  out  XLEN  address of inst_data.
- fetch_busy  out  1  outstanding != 0 or FIFO not empty.

Behaviour:
- Reset (rst low, asynchronous): fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty. Outputs: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_busy=0.
- First request is raised in the first cycle after rst deasserts.
- Request condition: imem_req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING && (count + outstanding - drop_cnt) < DEPTH. This credit rule guarantees a FIFO slot for every live response; no response is ever lost.
- imem_req_addr = fetch_pc, with bits [1:0] always 0. Valid and address hold stable until ready is seen.
- Handshake fires (valid && ready): fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1, and the request's pc enters a MAX_OUTSTANDING-deep in-order pc tag queue.
- Response: outstanding -= 1 and the tag queue pops.
  - drop_cnt > 0: word discarded, drop_cnt -= 1.
  - Otherwise {tag pc, data} pushed to the FIFO.
- Simultaneous request fire and response in one cycle: outstanding unchanged.
- Output: inst_valid = FIFO not empty; inst_data/inst_pc = FIFO head. Pop on inst_valid && inst_ready. Load-to-use latency is 1 cycle (response cycle N, inst_valid in cycle N+1).
- Full FIFO with push and pop in the same cycle: both occur, count unchanged. Empty FIFO with pop: impossible, since inst_valid=0.
- Redirect (redirect_valid=1), taking effect in the same cycle:
  - FIFO flushed; inst_valid=0 next cycle.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding_next, i.e. all in-flight responses are dropped, including one arriving this cycle.
  - imem_req_valid is 0 in the redirect cycle; fetch resumes the next cycle at the new pc.
  - A redirect arriving while drop_cnt > 0 accumulates correctly.
- Decode holding inst_ready=0: FIFO fills, then requests stop. No overflow, no underflow.

Optional Feature:
- FETCH_BYPASS_EN defined: when the FIFO is empty, drop_cnt==0, a response is valid and no redirect is active, the response drives inst_valid/inst_data/inst_pc combinationally in the same cycle. If inst_ready=1 the word is not written to the FIFO; otherwise it is pushed normally. Latency becomes 0.
- Undefined: the registered path only, with 1-cycle latency.

Decomposition:
- Shared package fetch_pkg holds: XLEN default, RESET_PC default, NOP constant 32'h0000_0013, and a fetch_entry_t struct {pc, data}.
- One sub-module, pf_sync_fifo, implementing the FIFO: DEPTH, WIDTH=2*XLEN, push/pop/flush, count, full/empty. Reused for the tag queue.

Test Plan:
- Reset release, imem always ready, rsp 1 cycle later, inst_ready=1 → inst_pc streams 0x0,0x4,0x8,... back-to-back after the initial latency; fetch_busy=1.
- inst_ready=0 for 20 cycles, DEPTH=4 → exactly 4 entries buffered (pc 0x0..0xC), imem_req_valid=0; releasing inst_ready drains in order.
- 2 requests outstanding, redirect to 0x100 → both stale responses dropped; next inst_pc=0x100 with its data; no 0x8/0xC seen.
- redirect_pc=0x203 → imem_req_addr=0x200 the following cycle.
- imem_req_ready toggling randomly, response delay 3 cycles, MAX_OUTSTANDING=2 → never more than 2 in flight; instruction sequence identical to the ideal-memory run.
- rst asserted mid-stream with 2 in flight → all outputs 0 immediately; after release, fetch restarts at RESET_PC.
